// File: rtl/pit_tone_sequencer.sv
// Plays (divisor, duration) tones by programming PIT counter 2 and the 61h gate on cycles the CPU leaves free.
// Optional PIT_TONE_QUEUE_EN macro selects a QDEPTH-entry FIFO with gapless chaining instead of a single holding register.
module pit_tone_sequencer #(
   parameter int MS_HZ  = 1000,
   parameter int QDEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [27:0] clock_rate,
   input  logic        tone_valid,
   output logic        tone_ready,
   input  logic [15:0] tone_divisor,
   input  logic [15:0] tone_duration,
   input  logic        abort,
   output logic        busy,
   input  logic [2:0]  cpu_io_address,
   input  logic        cpu_io_read,
   input  logic        cpu_io_write,
   input  logic [7:0]  cpu_io_writedata,
   output logic [2:0]  pit_io_address,
   output logic        pit_io_read,
   output logic        pit_io_write,
   output logic [7:0]  pit_io_writedata
);

   typedef enum logic [2:0] {IDLE, CTRL, LSB, MSB, GATE, PLAY, STOP} state_t;

   state_t      state, state_nx;
   logic [27:0] rate_q;
   logic [27:0] acc;
   logic [28:0] acc_sum;
   logic        tick;

   logic [15:0] cur_div, cur_dur, remaining;
   logic        silent, silent_nx;
   logic        q_push, q_pop, q_empty, load, start_play;
   logic [31:0] head;
   logic [15:0] head_div, head_dur;

   logic        cpu_act, grant, conflict;
   logic        seq_req;
   logic [2:0]  seq_addr;
   logic [7:0]  seq_data;

   // fractional divider: one tick per ms regardless of clk frequency
   assign acc_sum = {1'b0, acc} + 29'(MS_HZ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rate_q <= '0;
         acc    <= '0;
         tick   <= 1'b0;
      end else begin
         rate_q <= clock_rate;
         if (acc_sum >= {1'b0, rate_q}) begin
            acc  <= 28'(acc_sum - {1'b0, rate_q});
            tick <= 1'b1;
         end else begin
            acc  <= acc_sum[27:0];
            tick <= 1'b0;
         end
      end
   end

   assign cpu_act  = cpu_io_read | cpu_io_write;
   assign grant    = seq_req & ~cpu_act;
   // CPU touching counter 2 data or reprogramming counter 2 resets the PIT LSB/MSB toggle
   assign conflict = cpu_io_write &
                     ((cpu_io_address == 3'd2) ||
                      ((cpu_io_address == 3'd3) && (cpu_io_writedata[7:6] == 2'b10)));

   assign pit_io_address   = cpu_act ? cpu_io_address   : seq_addr;
   assign pit_io_writedata = cpu_act ? cpu_io_writedata : seq_data;
   assign pit_io_read      = cpu_act ? cpu_io_read      : 1'b0;
   assign pit_io_write     = cpu_act ? cpu_io_write     : seq_req;

   assign q_push   = tone_valid & tone_ready & ~abort;
   assign head_div = head[31:16];
   assign head_dur = head[15:0];

`ifdef PIT_TONE_QUEUE_EN
   localparam int  AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam bit  CHAIN_EN = 1'b1;

   logic [31:0] mem [QDEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   assign q_empty    = (count == '0);
   assign tone_ready = (count != (AW+1)'(QDEPTH));
   assign head       = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (q_push) begin
            mem[wr_ptr] <= {tone_divisor, tone_duration};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (q_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({q_push, q_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
`else
   localparam bit CHAIN_EN = 1'b0;

   logic        held;
   logic [31:0] hold_q;

   assign q_empty    = ~held;
   assign tone_ready = (state == IDLE) && !held;
   assign head       = hold_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held   <= 1'b0;
         hold_q <= '0;
      end else if (abort) begin
         held <= 1'b0;
      end else if (q_push) begin
         held   <= 1'b1;
         hold_q <= {tone_divisor, tone_duration};
      end else if (q_pop) begin
         held <= 1'b0;
      end
   end
`endif

   always_comb begin
      state_nx   = state;
      silent_nx  = silent;
      q_pop      = 1'b0;
      load       = 1'b0;
      start_play = 1'b0;
      seq_req    = 1'b0;
      seq_addr   = 3'd0;
      seq_data   = 8'h00;
      case (state)
         IDLE: begin
            if (!abort && !q_empty) begin
               q_pop = 1'b1;
               if (head_dur != 16'd0) begin
                  load      = 1'b1;
                  silent_nx = (head_div == 16'd0);
                  state_nx  = (head_div == 16'd0) ? STOP : CTRL;
               end
            end
         end
         CTRL: begin
            seq_req  = 1'b1;
            seq_addr = 3'd3;
            seq_data = 8'hB6;
            if (abort) begin
               state_nx  = STOP;
               silent_nx = 1'b0;
            end else if (grant) begin
               state_nx = LSB;
            end
         end
         LSB: begin
            seq_req  = 1'b1;
            seq_addr = 3'd2;
            seq_data = cur_div[7:0];
            if (abort) begin
               state_nx  = STOP;
               silent_nx = 1'b0;
            end else if (conflict) begin
               state_nx = CTRL;
            end else if (grant) begin
               state_nx = MSB;
            end
         end
         MSB: begin
            seq_req  = 1'b1;
            seq_addr = 3'd2;
            seq_data = cur_div[15:8];
            if (abort) begin
               state_nx  = STOP;
               silent_nx = 1'b0;
            end else if (conflict) begin
               state_nx = CTRL;
            end else if (grant) begin
               state_nx = GATE;
            end
         end
         GATE: begin
            seq_req  = 1'b1;
            seq_addr = 3'd4;
            seq_data = 8'h03;
            if (abort) begin
               state_nx  = STOP;
               silent_nx = 1'b0;
            end else if (grant) begin
               state_nx   = PLAY;
               start_play = 1'b1;
            end
         end
         PLAY: begin
            if (abort) begin
               state_nx  = STOP;
               silent_nx = 1'b0;
            end else if (tick && remaining <= 16'd1) begin
               if (CHAIN_EN && !q_empty && head_dur != 16'd0) begin
                  // gapless: speaker stays gated while the next divisor is loaded
                  q_pop     = 1'b1;
                  load      = 1'b1;
                  silent_nx = (head_div == 16'd0);
                  state_nx  = (head_div == 16'd0) ? STOP : CTRL;
               end else if (silent) begin
                  state_nx  = IDLE;
                  silent_nx = 1'b0;
               end else begin
                  state_nx = STOP;
               end
            end
         end
         STOP: begin
            seq_req  = 1'b1;
            seq_addr = 3'd4;
            seq_data = 8'h00;
            if (grant) begin
               if (silent) begin
                  state_nx   = PLAY;
                  start_play = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         silent    <= 1'b0;
         cur_div   <= '0;
         cur_dur   <= '0;
         remaining <= '0;
         busy      <= 1'b0;
      end else begin
         state  <= state_nx;
         silent <= silent_nx;
         if (load) begin
            cur_div <= head_div;
            cur_dur <= head_dur;
         end
         if (start_play)
            remaining <= cur_dur;
         else if (state == PLAY && tick && remaining != 16'd0)
            remaining <= remaining - 16'd1;
         busy <= (state != IDLE) || !q_empty;
      end
   end

endmodule
